// File: rtl/adder_pkg.sv
// Shared types and elaboration-time parameter checks for the multicycle adder.
package adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic bit params_legal(int unsigned width, int unsigned chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/ripple_chunk.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into its MSB.
module ripple_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic carry;

  always_comb begin
    carry   = cin_i;
    c_msb_o = 1'b0;
    s_o     = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (i == int'(CHUNK) - 1) c_msb_o = carry;
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/multicycle_adder.sv
// Adder/subtractor that sums one CHUNK-bit slice per cycle, LSB slice first,
// with valid/ready handshakes on both operand and result sides.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  if (!params_legal(WIDTH, CHUNK)) begin : g_bad_params
    $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q, sum_upd;
  logic              carry_q, cout_q, ovf_q, zero_q, out_valid_q, in_ready_q;
  logic [CHUNK-1:0]  slice_s;
  logic              slice_cout, slice_c_msb, last_slice;

  ripple_chunk #(
    .CHUNK(CHUNK)
  ) u_ripple_chunk (
    .a_i    (a_q[idx_q*CHUNK +: CHUNK]),
    .b_i    (b_q[idx_q*CHUNK +: CHUNK]),
    .cin_i  (carry_q),
    .s_o    (slice_s),
    .cout_o (slice_cout),
    .c_msb_o(slice_c_msb)
  );

  assign last_slice = (idx_q == IdxW'(N - 1));

  // Sum register with the current slice merged in, so zero can be judged on the final value.
  always_comb begin
    sum_upd = sum_q;
    sum_upd[idx_q*CHUNK +: CHUNK] = slice_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b ^ {WIDTH{sub}};
            carry_q    <= sub | cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          sum_q   <= sum_upd;
          carry_q <= slice_cout;
          if (last_slice) begin
            cout_q      <= slice_cout;
            ovf_q       <= slice_c_msb ^ slice_cout;
            zero_q      <= (sum_upd == '0);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench: a 16/4 adder (main) and a 16/16 adder sharing the same stimulus.
module tb_multicycle_adder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;

  logic        in_ready, out_valid, cout, ovf, zero;
  logic [15:0] sum;
  logic        in_ready_w, out_valid_w, cout_w, ovf_w, zero_w;
  logic [15:0] sum_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut_w (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready_w),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid_w),
    .out_ready(out_ready),
    .sum      (sum_w),
    .cout     (cout_w),
    .ovf      (ovf_w),
    .zero     (zero_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves both DUTs holding their result in DONE.
  task automatic do_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                       input logic op_cin, input logic op_sub, input logic [18:0] exp_res);
    int lat, lat_w;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = op_a; b = op_b; cin = op_cin; sub = op_sub;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    lat_w = -1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid_w && lat_w < 0) lat_w = lat;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_result"}, {13'd0, cout, ovf, zero, sum}, {13'd0, exp_res});
    check({tag, "_latency_w"}, lat_w, 1);
    check({tag, "_result_w"}, {13'd0, cout_w, ovf_w, zero_w, sum_w}, {13'd0, exp_res});
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release"}, {28'd0, out_valid, in_ready, out_valid_w, in_ready_w}, 32'b0101);
  endtask

  logic [15:0] ba [3] = '{16'h0001, 16'hABCD, 16'h8000};
  logic [15:0] bb [3] = '{16'h0002, 16'h1111, 16'h0001};
  logic        bs [3] = '{1'b0, 1'b0, 1'b1};
  logic [18:0] be [3] = '{{3'b000, 16'h0003}, {3'b000, 16'hBCDE}, {3'b110, 16'h7FFF}};

  initial begin
    int k, res, last_t, stray;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check("reset_outputs", {12'd0, in_ready, out_valid, cout, ovf, zero, sum}, {12'd0, 5'b10000, 16'h0});
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Accepted on the first edge after reset release; {cout, ovf, zero, sum}
    do_op("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {3'b101, 16'h0000});
    release_result("ffff_plus_1");
    do_op("7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {3'b010, 16'h8000});
    release_result("7fff_plus_1");
    do_op("cin_ripple", 16'h00FF, 16'h0F00, 1'b1, 1'b0, {3'b000, 16'h1000});
    release_result("cin_ripple");
    do_op("5_minus_7", 16'h0005, 16'h0007, 1'b0, 1'b1, {3'b000, 16'hFFFE});

    // Stall the result while offering a new operand that must be ignored
    in_valid = 1'b1; a = 16'h0001; b = 16'h0001; sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_stable", {13'd0, out_valid, in_ready, cout, ovf, zero, sum},
            {13'd0, 5'b10000, 16'hFFFE});
    end
    in_valid = 1'b0;
    release_result("hold");

    // Reset in the second BUSY cycle aborts the operation
    in_valid = 1'b1; a = 16'h4321; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_outputs", {12'd0, in_ready, out_valid, cout, ovf, zero, sum}, {12'd0, 5'b10000, 16'h0});
    check("abort_outputs_w", {28'd0, in_ready_w, out_valid_w, zero_w, cout_w}, 32'b1000);
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("abort_no_valid", stray, 0);
    do_op("after_abort", 16'h1234, 16'h1111, 1'b0, 1'b0, {3'b000, 16'h2345});
    release_result("after_abort");

    // Back-to-back with out_ready tied high: one result every 6 cycles
    out_ready = 1'b1;
    k = 0; res = 0; last_t = -1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        if (res < 3) begin
          check("b2b_result", {13'd0, cout, ovf, zero, sum}, {13'd0, be[res]});
          if (res > 0) check("b2b_spacing", c - last_t, 6);
        end
        last_t = c;
        res++;
      end
      if (in_ready && k < 3) begin
        in_valid = 1'b1; a = ba[k]; b = bb[k]; sub = bs[k]; cin = 1'b0;
        k++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_count", res, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
